rdma_flow_mc: RTL and testbench

//  Per-flow outstanding-request limiter for the RoCE TX path; parametrised successor to the single-config flow block.

---
 rtl/rdma_flow_mc.sv | 171 +++++++++++++++++
 tb/tb_rdma_flow_mc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_flow_mc.sv
// rdma_flow_mc: per-flow outstanding-request limiter with coalesced ACK retirement.
// Each flow key owns an {occ, head} entry in a single-port table. The block zeroes the table itself after reset.
module rdma_flow_mc_fifo #(
    parameter int W = 8,
    parameter int D = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(D);
    logic [W-1:0] mem [D];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic pop;
    assign valid = cnt != '0;
    assign full = cnt == (AW+1)'(D);
    assign pop = valid && ready;
    assign dout = mem[rp];
    always_ff @(posedge aclk)
        if (push) mem[wp] <= din;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= (wp == AW'(D-1)) ? '0 : wp + AW'(1);
            if (pop) rp <= (rp == AW'(D-1)) ? '0 : rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

module rdma_flow_mc #(
    parameter int N_OST    = 16,
    parameter int KEY_BITS = 10,
    parameter int REQ_BITS = 128,
    parameter int ACK_BITS = 64,
    parameter int OFFS_LSB = 0,
    parameter int QDEPTH   = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      s_req_valid,
    output logic                      s_req_ready,
    input  logic [KEY_BITS-1:0]       s_req_key,
    input  logic [REQ_BITS-1:0]       s_req_data,
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic [REQ_BITS-1:0]       m_req_data,
    input  logic                      s_ack_valid,
    output logic                      s_ack_ready,
    input  logic [KEY_BITS-1:0]       s_ack_key,
    input  logic [$clog2(N_OST):0]    s_ack_cnt,
    input  logic                      s_ack_last,
    input  logic [ACK_BITS-1:0]       s_ack_data,
    output logic                      m_ack_valid,
    input  logic                      m_ack_ready,
    output logic [ACK_BITS-1:0]       m_ack_data,
    output logic                      init_done,
    output logic                      err_ack_ovf,
    output logic [15:0]               err_cnt
);
    localparam int OB = $clog2(N_OST);
    localparam int EW = 2*OB + 1;
    localparam int TBL = 2**KEY_BITS;
    typedef enum logic [2:0] {INIT, IDLE, A_RD, A_UPD, R_RD, R_UPD} state_t;
    state_t state, state_n;
    logic [KEY_BITS-1:0] sweep, key_q, addr;
    logic [OB:0] cnt_q, occ, c, occ_n;
    logic [OB-1:0] head;
    logic [EW-1:0] tbl [TBL];
    logic [EW-1:0] rd_q, wdata;
    logic we, ack_ok, ack_push, req_push, req_full, ack_full, ovf;
    logic [REQ_BITS-1:0] req_din;

    assign {occ, head} = rd_q;
    assign addr = (state == INIT) ? sweep : key_q;
    // a last-ACK with a full completion FIFO is refused so the request path can still proceed
    assign ack_ok = s_ack_valid && !(s_ack_last && ack_full);
    assign c = (cnt_q == '0) ? (OB+1)'(1) : cnt_q;
    assign ovf = (state == A_UPD) && (c > occ);
    assign occ_n = ovf ? '0 : occ - c;

    always_comb begin
        req_din = s_req_data;
        req_din[OFFS_LSB +: OB] = head;
    end

    always_comb begin
        state_n = state;
        s_ack_ready = 1'b0;
        s_req_ready = 1'b0;
        ack_push = 1'b0;
        req_push = 1'b0;
        we = 1'b0;
        wdata = '0;
        case (state)
            INIT: begin
                we = 1'b1;
                state_n = (&sweep) ? IDLE : INIT;
            end
            IDLE:
                if (ack_ok) begin
                    s_ack_ready = 1'b1;
                    ack_push = s_ack_last;
                    state_n = A_RD;
                end else if (s_req_valid && !req_full) begin
                    state_n = R_RD;
                end
            A_RD: state_n = A_UPD;
            A_UPD: begin
                we = 1'b1;
                wdata = {occ_n, head};
                state_n = IDLE;
            end
            R_RD: state_n = R_UPD;
            R_UPD: begin
                state_n = IDLE;
                if (s_req_valid && !occ[OB]) begin
                    s_req_ready = 1'b1;
                    req_push = 1'b1;
                    we = 1'b1;
                    wdata = {occ + (OB+1)'(1), head + OB'(1)};
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (we) tbl[addr] <= wdata;
        rd_q <= tbl[addr];
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state <= INIT;
            sweep <= '0;
            init_done <= 1'b0;
            key_q <= '0;
            cnt_q <= '0;
            err_ack_ovf <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == INIT) sweep <= sweep + KEY_BITS'(1);
            if (state == INIT && &sweep) init_done <= 1'b1;
            if (state == IDLE) begin
                key_q <= ack_ok ? s_ack_key : s_req_key;
                cnt_q <= s_ack_cnt;
            end
            err_ack_ovf <= ovf;
            if (ovf && !(&err_cnt)) err_cnt <= err_cnt + 16'd1;
        end

    rdma_flow_mc_fifo #(.W(REQ_BITS), .D(QDEPTH)) u_req_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(req_push), .din(req_din), .full(req_full),
        .valid(m_req_valid), .ready(m_req_ready), .dout(m_req_data)
    );

    rdma_flow_mc_fifo #(.W(ACK_BITS), .D(QDEPTH)) u_ack_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(ack_push), .din(s_ack_data), .full(ack_full),
        .valid(m_ack_valid), .ready(m_ack_ready), .dout(m_ack_data)
    );
endmodule

// File: tb/tb_rdma_flow_mc.sv
// tb_rdma_flow_mc: directed vector table, hand sequences and randomized traffic against a per-flow occupancy model.
module tb_rdma_flow_mc;
    localparam int N_OST = 4, KB = 4, RB = 32, AB = 16, OFFS = 4, QD = 4, TBL = 16;
    logic aclk = 1'b0, aresetn = 1'b1;
    logic s_req_valid = 1'b0, s_req_ready;
    logic [KB-1:0] s_req_key = '0;
    logic [RB-1:0] s_req_data = '0;
    logic m_req_valid, m_req_ready = 1'b1;
    logic [RB-1:0] m_req_data;
    logic s_ack_valid = 1'b0, s_ack_ready;
    logic [KB-1:0] s_ack_key = '0;
    logic [2:0] s_ack_cnt = '0;
    logic s_ack_last = 1'b0;
    logic [AB-1:0] s_ack_data = '0;
    logic m_ack_valid, m_ack_ready = 1'b1;
    logic [AB-1:0] m_ack_data;
    logic init_done, err_ack_ovf;
    logic [15:0] err_cnt;

    rdma_flow_mc #(.N_OST(N_OST), .KEY_BITS(KB), .REQ_BITS(RB), .ACK_BITS(AB), .OFFS_LSB(OFFS), .QDEPTH(QD)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_key(s_req_key), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
        .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_key(s_ack_key), .s_ack_cnt(s_ack_cnt),
        .s_ack_last(s_ack_last), .s_ack_data(s_ack_data),
        .m_ack_valid(m_ack_valid), .m_ack_ready(m_ack_ready), .m_ack_data(m_ack_data),
        .init_done(init_done), .err_ack_ovf(err_ack_ovf), .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_pass = 0;
    int m_occ[16], m_head[16];
    int m_err = 0;
    logic [31:0] got_req[$], got_ack[$];

    always @(negedge aclk) begin
        #2;
        if (m_req_valid && m_req_ready) got_req.push_back(m_req_data);
        if (m_ack_valid && m_ack_ready) got_ack.push_back(32'(m_ack_data));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int mdl_req(input int k);
        int slot = m_head[k];
        m_head[k] = (m_head[k] + 1) % N_OST;
        m_occ[k]++;
        return slot;
    endfunction

    function automatic bit mdl_ack(input int k, input int cnt);
        int c = (cnt == 0) ? 1 : cnt;
        if (c > m_occ[k]) begin
            m_occ[k] = 0;
            if (m_err < 65535) m_err++;
            return 1'b1;
        end
        m_occ[k] -= c;
        return 1'b0;
    endfunction

    task automatic get_beat(input bit is_ack, output logic [31:0] g, output bit ok);
        ok = 1'b0;
        g = '0;
        for (int i = 0; i < 12; i++) begin
            if ((is_ack && got_ack.size() != 0) || (!is_ack && got_req.size() != 0)) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
            #3;
        end
        if (ok) begin
            if (is_ack) g = got_ack.pop_front();
            else g = got_req.pop_front();
        end
    endtask

    task automatic req_check(input string nm, input logic [3:0] k, input logic [31:0] d, input bit start,
                             input bit exp_acc, input logic [1:0] slot, output bit ok);
        logic [31:0] e, g;
        bit got;
        if (start) begin
            s_req_key = k;
            s_req_data = d;
            s_req_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (s_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (ok) begin
            @(negedge aclk);
            s_req_valid = 1'b0;
        end
        chk({nm, " accepted"}, 64'(ok), 64'(exp_acc));
        if (ok) begin
            e = d;
            e[OFFS +: 2] = slot;
            get_beat(1'b0, g, got);
            chk({nm, " m_req present"}, 64'(got), 64'(1));
            if (got) chk({nm, " m_req data"}, 64'(g), 64'(e));
        end
    endtask

    task automatic ack_check(input string nm, input logic [3:0] k, input logic [2:0] cnt, input bit last,
                             input logic [15:0] d, input bit start, input bit exp_acc, input bit exp_ovf,
                             input logic [15:0] exp_err, output bit ok);
        int pulses;
        logic [31:0] g;
        bit got;
        if (start) begin
            s_ack_key = k;
            s_ack_cnt = cnt;
            s_ack_last = last;
            s_ack_data = d;
            s_ack_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (s_ack_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        chk({nm, " accepted"}, 64'(ok), 64'(exp_acc));
        if (ok) begin
            @(negedge aclk);
            s_ack_valid = 1'b0;
            pulses = 0;
            for (int j = 0; j < 4; j++) begin
                @(negedge aclk);
                #1;
                if (err_ack_ovf) pulses++;
            end
            chk({nm, " ovf pulses"}, 64'(pulses), 64'(exp_ovf));
            chk({nm, " err_cnt"}, 64'(err_cnt), 64'(exp_err));
            if (last && m_ack_ready) begin
                get_beat(1'b1, g, got);
                chk({nm, " m_ack present"}, 64'(got), 64'(1));
                if (got) chk({nm, " m_ack data"}, 64'(g), 64'(d));
            end
        end
    endtask

    task automatic do_reset();
        int cyc;
        bit seen;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("rst init_done", 64'(init_done), 64'(0));
        chk("rst m_req_valid", 64'(m_req_valid), 64'(0));
        chk("rst m_ack_valid", 64'(m_ack_valid), 64'(0));
        chk("rst err_cnt", 64'(err_cnt), 64'(0));
        chk("rst err_ack_ovf", 64'(err_ack_ovf), 64'(0));
        chk("rst s_ack_ready", 64'(s_ack_ready), 64'(0));
        got_req.delete();
        got_ack.delete();
        foreach (m_occ[i]) begin
            m_occ[i] = 0;
            m_head[i] = 0;
        end
        m_err = 0;
        @(negedge aclk);
        s_req_key = 4'd1;
        s_req_valid = 1'b1;
        s_ack_key = 4'd1;
        s_ack_cnt = 3'd1;
        s_ack_last = 1'b0;
        s_ack_valid = 1'b1;
        aresetn = 1'b1;
        cyc = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge aclk);
            #1;
            if (init_done) begin
                cyc = i;
                break;
            end
            if (s_req_ready || s_ack_ready) seen = 1'b1;
        end
        s_req_valid = 1'b0;
        s_ack_valid = 1'b0;
        chk("init sweep cycles", 64'(cyc), 64'(TBL));
        chk("ready during init", 64'(seen), 64'(0));
    endtask

    typedef struct {
        bit ack;
        bit start;
        logic [3:0] key;
        logic [2:0] cnt;
        bit last;
        logic [31:0] data;
        bit acc;
        logic [1:0] slot;
        bit ovf;
        logic [15:0] err;
    } vec_t;

    vec_t vec[15];

    initial begin
        bit ok, ovf, got;
        int slot;
        logic [3:0] k;
        logic [2:0] cnt;
        bit last;
        logic [31:0] d, g;
        vec = '{
            '{0, 1, 4'd5, 3'd0, 0, 32'h1000_0001, 1, 2'd0, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h2000_0002, 1, 2'd1, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h3000_0003, 1, 2'd2, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h4000_0004, 1, 2'd3, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h5000_00F5, 0, 2'd0, 0, 16'd0},
            '{1, 1, 4'd5, 3'd2, 1, 32'h0000_AC01, 1, 2'd0, 0, 16'd0},
            '{0, 0, 4'd5, 3'd0, 0, 32'h5000_00F5, 1, 2'd0, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h6000_0006, 1, 2'd1, 0, 16'd0},
            '{1, 1, 4'd5, 3'd4, 0, 32'h0000_0000, 1, 2'd0, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h7000_0007, 1, 2'd2, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h8000_0008, 1, 2'd3, 0, 16'd0},
            '{0, 1, 4'd5, 3'd0, 0, 32'h9000_0009, 1, 2'd0, 0, 16'd0},
            '{1, 1, 4'd5, 3'd5, 1, 32'h0000_AC0C, 1, 2'd0, 1, 16'd1},
            '{1, 1, 4'd5, 3'd0, 0, 32'h0000_0000, 1, 2'd0, 1, 16'd2},
            '{0, 1, 4'd5, 3'd0, 0, 32'hA000_000A, 1, 2'd1, 0, 16'd2}
        };

        do_reset();

        for (int i = 0; i < 15; i++) begin
            if (vec[i].ack) begin
                ack_check($sformatf("vec%0d ack", i), vec[i].key, vec[i].cnt, vec[i].last, vec[i].data[15:0],
                          vec[i].start, vec[i].acc, vec[i].ovf, vec[i].err, ok);
                if (ok) void'(mdl_ack(int'(vec[i].key), int'(vec[i].cnt)));
            end else begin
                req_check($sformatf("vec%0d req", i), vec[i].key, vec[i].data, vec[i].start, vec[i].acc,
                          vec[i].slot, ok);
                if (ok) void'(mdl_req(int'(vec[i].key)));
            end
        end

        // ACK and request presented together: ACK must win, the other flow is unaffected
        s_ack_key = 4'd5;
        s_ack_cnt = 3'd1;
        s_ack_last = 1'b1;
        s_ack_data = 16'h5A5A;
        s_ack_valid = 1'b1;
        s_req_key = 4'd9;
        s_req_data = 32'hCAFE_0000;
        s_req_valid = 1'b1;
        #1;
        chk("prio s_ack_ready", 64'(s_ack_ready), 64'(1));
        chk("prio s_req_ready", 64'(s_req_ready), 64'(0));
        @(negedge aclk);
        s_ack_valid = 1'b0;
        void'(mdl_ack(5, 1));
        req_check("prio req key9", 4'd9, 32'hCAFE_0000, 1'b0, 1'b1, 2'd0, ok);
        if (ok) void'(mdl_req(9));
        get_beat(1'b1, g, got);
        chk("prio m_ack present", 64'(got), 64'(1));
        if (got) chk("prio m_ack data", 64'(g), 64'(16'h5A5A));
        chk("prio err_cnt", 64'(err_cnt), 64'(m_err));

        for (int i = 0; i < 80; i++) begin
            k = 4'($urandom_range(0, 3));
            d = $urandom;
            if (m_occ[k] == N_OST || $urandom_range(0, 2) == 0) begin
                cnt = 3'($urandom_range(0, 5));
                last = 1'($urandom_range(0, 1));
                ovf = mdl_ack(int'(k), int'(cnt));
                ack_check("rnd ack", k, cnt, last, d[15:0], 1'b1, 1'b1, ovf, 16'(m_err), ok);
            end else begin
                slot = mdl_req(int'(k));
                req_check("rnd req", k, d, 1'b1, 1'b1, 2'(slot), ok);
            end
        end

        // completion FIFO backpressure: fill it, the next last-ACK stalls, requests still flow
        m_ack_ready = 1'b0;
        for (int i = 0; i < QD; i++) begin
            ovf = mdl_ack(2, 1);
            ack_check($sformatf("fill ack%0d", i), 4'd2, 3'd1, 1'b1, 16'(16'hB000 + i), 1'b1, 1'b1, ovf,
                      16'(m_err), ok);
        end
        ack_check("stall ack", 4'd2, 3'd1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd0, ok);
        chk("ack fifo holding", 64'(m_ack_valid), 64'(1));
        slot = mdl_req(7);
        req_check("req past stalled ack", 4'd7, 32'h7777_0000, 1'b1, 1'b1, 2'(slot), ok);
        do_reset();
        m_ack_ready = 1'b1;
        req_check("req after resweep", 4'd7, 32'h7777_0011, 1'b1, 1'b1, 2'd0, ok);
        if (ok) void'(mdl_req(7));
        ovf = mdl_ack(7, 1);
        ack_check("ack after resweep", 4'd7, 3'd1, 1'b1, 16'h0777, 1'b1, 1'b1, ovf, 16'(m_err), ok);
        chk("final err_cnt", 64'(err_cnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
